// File: rtl/lcd_frame_reader_pkg.sv
// Shared constants, RGB565 colors and FSM encoding
// for the framebuffer read-back path.
package lcd_frame_reader_pkg;

  localparam int unsigned DEF_H_PIXELS   = 480;
  localparam int unsigned DEF_V_LINES    = 272;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned BURST_LEN      = 4;

  localparam logic [23:0] DEF_FB_BASE_ADDR = 24'h000000;

  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;

  localparam logic [15:0] DEF_BLANK_COLOR = COLOR_BLACK;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CHECK,
    S_REQ,
    S_PUSH,
    S_DONE
  } state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock 16-bit pixel FIFO with flush.
// rd_data shows the head word combinationally.
module pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign rd_data = mem_q[rp_q];
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + AW'(1);
      if (do_rd) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_wr}
                     - {{AW{1'b0}}, do_rd};
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(wr_en && full && !flush));

endmodule

// File: rtl/lcd_frame_reader.sv
// Framebuffer read-back: fetches 4-pixel SDRAM bursts into
// a pixel FIFO and serves one pixel per LCD request.
module lcd_frame_reader
  import lcd_frame_reader_pkg::*;
#(
  parameter int unsigned H_PIXELS     = DEF_H_PIXELS,
  parameter int unsigned V_LINES      = DEF_V_LINES,
  parameter logic [23:0] FB_BASE_ADDR = DEF_FB_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter logic [15:0] BLANK_COLOR  = DEF_BLANK_COLOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iFrame_Start,
  input  logic        iPixel_Req,
  output logic [15:0] oPixel_Data,
  output logic        oPixel_Valid,
  output logic        oUnderflow,
  output logic        oFrame_Fetched,
  output logic [23:0] oSDRAM_Rd_Addr,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  input  logic [15:0] iSDRAM_Rd_Data1,
  input  logic [15:0] iSDRAM_Rd_Data2,
  input  logic [15:0] iSDRAM_Rd_Data3,
  input  logic [15:0] iSDRAM_Rd_Data4
);

  localparam int unsigned FRAME_PIX = H_PIXELS * V_LINES;
  localparam int unsigned BURSTS    = FRAME_PIX / BURST_LEN;
  localparam int unsigned BW        = $clog2(BURSTS + 1);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ROOM    = CW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [BW-1:0] LAST    = BW'(BURSTS);

  state_e          state_q, state_d;
  logic [23:0]     addr_q, addr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [1:0]      beat_q, beat_d;
  logic            pend_q, pend_d;
  logic            got_q, got_d;
  logic [3:0][15:0] hold_q, hold_d;
  logic [15:0]     pix_q;
  logic            vld_q;
  logic            udf_q;

  logic            start;
  logic            restart;
  logic            req;
  logic            wr_en;
  logic            rd_en;
  logic [15:0]     head;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;

  assign start = en && iFrame_Start;
  assign rd_en = iPixel_Req && !empty;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    beat_d  = beat_q;
    pend_d  = pend_q;
    got_d   = got_q;
    hold_d  = hold_q;
    req     = 1'b0;
    wr_en   = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE: restart = start;
      S_ARM: begin
        if (start) restart = 1'b1;
        else if (en) begin
          addr_d  = FB_BASE_ADDR;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (start) restart = 1'b1;
        else if (en) begin
          if (bcnt_q == LAST) state_d = S_DONE;
          else if (count <= ROOM) state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Handshake always completes; a frame start only queues a restart
        req = !got_q;
        if (iFrame_Start) pend_d = 1'b1;
        if (req && iSDRAM_Rd_Done) begin
          hold_d = {iSDRAM_Rd_Data4, iSDRAM_Rd_Data3,
                    iSDRAM_Rd_Data2, iSDRAM_Rd_Data1};
          got_d  = 1'b1;
        end
        if (en && got_d) begin
          got_d = 1'b0;
          if (pend_d) restart = 1'b1;
          else begin
            state_d = S_PUSH;
            beat_d  = '0;
          end
        end
      end
      S_PUSH: begin
        if (start) restart = 1'b1;
        else if (en) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            addr_d  = addr_q + 24'(BURST_LEN);
            bcnt_d  = bcnt_q + BW'(1);
            state_d = S_CHECK;
          end
        end
      end
      S_DONE: restart = start;
      default: state_d = S_IDLE;
    endcase
    if (restart) begin
      state_d = S_ARM;
      addr_d  = FB_BASE_ADDR;
      bcnt_d  = '0;
      pend_d  = 1'b0;
      got_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= FB_BASE_ADDR;
      bcnt_q  <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      got_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      got_q   <= got_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      vld_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      vld_q <= rd_en;
      if (rd_en) pix_q <= head;
      else if (iPixel_Req) pix_q <= BLANK_COLOR;
      if (restart) udf_q <= 1'b0;
      else if (iPixel_Req && empty) udf_q <= 1'b1;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (restart),
    .wr_en   (wr_en),
    .wr_data (hold_q[beat_q]),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign oPixel_Data    = pix_q;
  assign oPixel_Valid   = vld_q;
  assign oUnderflow     = udf_q;
  assign oFrame_Fetched = (state_q == S_DONE);
  assign oSDRAM_Rd_Addr = addr_q;
  assign oSDRAM_Rd_Req  = req;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Bench for lcd_frame_reader: SDRAM responder backed by a
// pixel array, expected stream taken from that array in order.
`timescale 1ns/1ps
module tb_lcd_frame_reader;
  import lcd_frame_reader_pkg::*;

  localparam int NPIX = 16;
  localparam int FD   = 8;
  localparam logic [15:0] BLANK = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        fs = 1'b0;
  logic        preq = 1'b0;
  logic        done = 1'b0;
  logic [15:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic [15:0] pix;
  logic        vld, udf, fetched, rreq;
  logic [23:0] raddr;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem [NPIX];
  int addr_log[$];
  bit stall = 1'b0;
  bit rand_lat = 1'b0;
  int lat = 3;

  always #5 clk = ~clk;

  lcd_frame_reader #(
    .H_PIXELS   (8),
    .V_LINES    (2),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .iFrame_Start    (fs),
    .iPixel_Req      (preq),
    .oPixel_Data     (pix),
    .oPixel_Valid    (vld),
    .oUnderflow      (udf),
    .oFrame_Fetched  (fetched),
    .oSDRAM_Rd_Addr  (raddr),
    .oSDRAM_Rd_Req   (rreq),
    .iSDRAM_Rd_Done  (done),
    .iSDRAM_Rd_Data1 (d1),
    .iSDRAM_Rd_Data2 (d2),
    .iSDRAM_Rd_Data3 (d3),
    .iSDRAM_Rd_Data4 (d4)
  );

  // SDRAM model: answers a held request after a latency
  initial begin : responder
    int wc;
    int cur;
    int a;
    bit last;
    wc = 0; cur = 3; last = 1'b0;
    forever begin
      @(negedge clk);
      if (last) begin
        checks++;
        if (rreq !== 1'b0) begin
          errors++;
          $display("FAIL req_after_done: got %b expected 0", rreq);
        end
      end
      done = 1'b0;
      last = 1'b0;
      if (rreq === 1'b1 && !stall) begin
        if (wc == 0) cur = rand_lat ? int'($urandom_range(1, 4)) : lat;
        wc++;
        if (wc >= cur) begin
          a = int'(raddr);
          d1 = mem[(a + 0) % NPIX];
          d2 = mem[(a + 1) % NPIX];
          d3 = mem[(a + 2) % NPIX];
          d4 = mem[(a + 3) % NPIX];
          done = 1'b1;
          last = 1'b1;
          addr_log.push_back(a);
          wc = 0;
        end
      end else if (rreq !== 1'b1) begin
        wc = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_frame();
    @(negedge clk); fs = 1'b1;
    @(negedge clk); fs = 1'b0;
  endtask

  task automatic wait_full(output bit ok);
    int n = 0;
    while (!(dut.u_fifo.count == FD && dut.state_q == S_CHECK)
           && n < 400) begin
      @(negedge clk); n++;
    end
    ok = (n < 400);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix, vld, udf, fetched, rreq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b/%b expected all 0",
               pix, vld, udf, fetched, rreq);
    end
    checks++;
    if (raddr !== 24'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 000000", raddr);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dut.u_fifo.empty !== 1'b1 || rreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: empty %b req %b expected 1 0",
               dut.u_fifo.empty, rreq);
    end
  endtask

  task automatic test_basic_fetch();
    bit ok;
    for (int k = 0; k < NPIX; k++) mem[k] = 16'(k + 1);
    lat = 3; rand_lat = 1'b0; stall = 1'b0;
    addr_log.delete();
    start_frame();
    wait_full(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_fill: count %0d expected %0d",
               dut.u_fifo.count, FD);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (addr_log.size() != 2 || addr_log[0] != 0 || addr_log[1] != 4) begin
      errors++;
      $display("FAIL basic_addrs: got %p expected '{0, 4}", addr_log);
    end
    checks++;
    if (rreq !== 1'b0 || dut.u_fifo.count != FD) begin
      errors++;
      $display("FAIL basic_withheld: req %b count %0d expected 0 %0d",
               rreq, dut.u_fifo.count, FD);
    end
  endtask

  task automatic test_full_drain();
    int got = 0, issued = 0, gap = 0, n = 0;
    bit prev = 1'b0;
    rand_lat = 1'b1;
    while (got < NPIX && n < 800) begin
      @(negedge clk); n++;
      if (prev) begin
        checks++;
        if (vld !== 1'b1 || pix !== mem[got]) begin
          errors++;
          $display("FAIL drain_pixel%0d: got %h/%b expected %h/1",
                   got, pix, vld, mem[got]);
        end
        got++;
      end
      gap++;
      prev = 1'b0;
      if (issued < NPIX && gap >= 3 && $urandom_range(0, 1) == 1) begin
        prev = 1'b1; issued++; gap = 0;
      end
      preq = prev;
    end
    preq = 1'b0;
    checks++;
    if (got != NPIX) begin
      errors++;
      $display("FAIL drain_count: got %0d expected %0d", got, NPIX);
    end
    n = 0;
    while (fetched !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (fetched !== 1'b1 || udf !== 1'b0) begin
      errors++;
      $display("FAIL drain_status: fetched %b udf %b expected 1 0",
               fetched, udf);
    end
    checks++;
    if (addr_log.size() != 4 || addr_log[0] != 0 || addr_log[1] != 4 ||
        addr_log[2] != 8 || addr_log[3] != 12) begin
      errors++;
      $display("FAIL drain_addrs: got %p expected '{0, 4, 8, 12}", addr_log);
    end
  endtask

  task automatic test_underflow();
    int n = 0;
    stall = 1'b1;
    start_frame();
    checks++;
    if (fetched !== 1'b0) begin
      errors++;
      $display("FAIL uf_fetched_clear: got %b expected 0", fetched);
    end
    preq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (vld !== 1'b0 || pix !== BLANK) begin
        errors++;
        $display("FAIL uf_blank%0d: got %h/%b expected %h/0",
                 i, pix, vld, BLANK);
      end
    end
    preq = 1'b0;
    checks++;
    if (udf !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: got %b expected 1", udf);
    end
    start_frame();
    stall = 1'b0;
    while (dut.state_q != S_ARM && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (udf !== 1'b0) begin
      errors++;
      $display("FAIL uf_cleared: got %b expected 0", udf);
    end
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    int n = 0;
    for (int k = 0; k < NPIX; k++) mem[k] = 16'($urandom);
    stall = 1'b0; rand_lat = 1'b1;
    start_frame();
    wait_full(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sim_fill: count %0d expected %0d",
               dut.u_fifo.count, FD);
    end
    preq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) preq = 1'b0;
      checks++;
      if (vld !== 1'b1 || pix !== mem[i]) begin
        errors++;
        $display("FAIL sim_pop%0d: got %h/%b expected %h/1",
                 i, pix, vld, mem[i]);
      end
    end
    while (dut.u_fifo.count != 5 && n < 100) begin @(negedge clk); n++; end
    preq = 1'b1;
    @(negedge clk);
    preq = 1'b0;
    checks++;
    if (dut.u_fifo.count != 5) begin
      errors++;
      $display("FAIL sim_count: got %0d expected 5", dut.u_fifo.count);
    end
    checks++;
    if (vld !== 1'b1 || pix !== mem[4]) begin
      errors++;
      $display("FAIL sim_head: got %h/%b expected %h/1", pix, vld, mem[4]);
    end
  endtask

  task automatic test_restart_req();
    bit ok;
    int n = 0;
    for (int k = 0; k < NPIX; k++) mem[k] = 16'($urandom);
    stall = 1'b0;
    start_frame();
    wait_full(ok);
    preq = 1'b1;
    repeat (4) @(negedge clk);
    preq = 1'b0;
    stall = 1'b1;
    while (!(rreq === 1'b1 && raddr == 24'd8) && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (rreq !== 1'b1 || raddr !== 24'd8) begin
      errors++;
      $display("FAIL rs_req8: req %b addr %h expected 1 000008", rreq, raddr);
    end
    start_frame();
    repeat (3) @(negedge clk);
    checks++;
    if (rreq !== 1'b1 || raddr !== 24'd8) begin
      errors++;
      $display("FAIL rs_held: req %b addr %h expected 1 000008", rreq, raddr);
    end
    addr_log.delete();
    stall = 1'b0;
    n = 0;
    while (addr_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (addr_log.size() < 2 || addr_log[0] != 8 || addr_log[1] != 0) begin
      errors++;
      $display("FAIL rs_addrs: got %p expected '{8, 0}", addr_log);
    end
    wait_full(ok);
    preq = 1'b1;
    for (int i = 0; i < FD; i++) begin
      @(negedge clk);
      if (i == FD - 1) preq = 1'b0;
      checks++;
      if (vld !== 1'b1 || pix !== mem[i]) begin
        errors++;
        $display("FAIL rs_pix%0d: got %h/%b expected %h/1",
                 i, pix, vld, mem[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    for (int k = 0; k < NPIX; k++) mem[k] = 16'($urandom) | 16'h0001;
    stall = 1'b0;
    start_frame();
    preq = 1'b1;
    @(negedge clk);
    preq = 1'b0;
    while (dut.u_fifo.count == 0 && n < 100) begin @(negedge clk); n++; end
    preq = 1'b1;
    @(negedge clk);
    preq = 1'b0;
    n = 0;
    while (!(dut.state_q == S_PUSH && dut.beat_q == 2'd2 &&
             raddr == 24'd4) && n < 100) begin
      @(negedge clk); n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix, vld, udf, fetched, rreq} !== '0 || raddr !== 24'h0) begin
      errors++;
      $display("FAIL arst_outputs: got %h/%b/%b/%b/%b/%h expected all 0",
               pix, vld, udf, fetched, rreq, raddr);
    end
    checks++;
    if (dut.u_fifo.empty !== 1'b1 || dut.state_q != S_IDLE) begin
      errors++;
      $display("FAIL arst_state: empty %b state %0d expected 1 0",
               dut.u_fifo.empty, dut.state_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    addr_log.delete();
    start_frame();
    n = 0;
    while (addr_log.size() < 1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (addr_log.size() < 1 || addr_log[0] != 0) begin
      errors++;
      $display("FAIL arst_refetch: got %p expected '{0, ...}", addr_log);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_full_drain();
    test_underflow();
    test_simul_push_pop();
    test_restart_req();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
